// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier result memory and its block reader.
package mult_pkg;
  localparam int MEM_DEPTH  = 64;
  localparam int MEM_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } reduce_state_t;
endpackage

// File: rtl/reduce_acc.sv
// Running sum/min/max/count over one block of streamed words.
module reduce_acc #(
  parameter int N     = 32,
  parameter int DEPTH = 64,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int SUM_W = N + $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             acc_en,
  input  logic [N-1:0]     data,
  output logic [SUM_W-1:0] sum,
  output logic [N-1:0]     min_val,
  output logic [N-1:0]     max_val,
  output logic [CNT_W-1:0] count
);
  logic [SUM_W-1:0] sum_reg;
  logic [N-1:0]     min_reg;
  logic [N-1:0]     max_reg;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sum_reg   <= '0;
      min_reg   <= '1;
      max_reg   <= '0;
      count_reg <= '0;
    end else if (clr) begin
      sum_reg   <= '0;
      min_reg   <= '1;
      max_reg   <= '0;
      count_reg <= '0;
    end else if (acc_en) begin
      sum_reg   <= sum_reg + SUM_W'(data);
      // The first word of a block seeds both extremes.
      if (count_reg == '0 || data < min_reg) min_reg <= data;
      if (count_reg == '0 || data > max_reg) max_reg <= data;
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign sum     = sum_reg;
  assign min_val = min_reg;
  assign max_val = max_reg;
  assign count   = count_reg;
endmodule

// File: rtl/block_reduce_reader.sv
// Requests a block from the multiplier memory, reduces the streamed words and
// presents one sum/min/max/count record on a valid/ready handshake.
module block_reduce_reader
  import mult_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = MEM_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int SUM_W = N + $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN_reduce,
  input  logic             VALID_memVal,
  input  logic [N-1:0]     memVal_data,
  output logic             EN_blockRead,
  output logic             VALID_result,
  input  logic             RDY_result,
  output logic [SUM_W-1:0] result_sum,
  output logic [N-1:0]     result_min,
  output logic [N-1:0]     result_max,
  output logic [CNT_W-1:0] result_count,
  output logic             ERR_short
);
  reduce_state_t    state_reg, state_next;
  logic             err_reg, err_next;
  logic             clr, acc_en, last_word;
  logic [SUM_W-1:0] acc_sum;
  logic [N-1:0]     acc_min, acc_max;
  logic [CNT_W-1:0] acc_count;

  reduce_acc #(.N(N), .DEPTH(DEPTH)) u_acc (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr     (clr),
    .acc_en  (acc_en),
    .data    (memVal_data),
    .sum     (acc_sum),
    .min_val (acc_min),
    .max_val (acc_max),
    .count   (acc_count)
  );

  // The word being accepted this cycle completes the block.
  assign last_word = (acc_count == CNT_W'(DEPTH - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    clr        = 1'b0;
    acc_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        clr      = 1'b1;
        err_next = 1'b0;
        if (EN_reduce) state_next = REQ;
      end
      REQ: begin
        // Data already streaming takes priority over a late disarm.
        if (VALID_memVal) begin
          acc_en     = 1'b1;
          state_next = last_word ? DONE : COLLECT;
        end else if (!EN_reduce) begin
          state_next = IDLE;
        end
      end
      COLLECT: begin
        if (VALID_memVal) begin
          acc_en = 1'b1;
          if (last_word) state_next = DONE;
        end else begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      DONE: begin
        if (RDY_result) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign EN_blockRead = (state_reg == REQ);
  assign VALID_result = (state_reg == DONE);
  assign result_sum   = VALID_result ? acc_sum   : '0;
  assign result_min   = VALID_result ? acc_min   : '0;
  assign result_max   = VALID_result ? acc_max   : '0;
  assign result_count = VALID_result ? acc_count : '0;
  assign ERR_short    = err_reg;
endmodule

// File: tb/tb_block_reduce_reader.sv
// Directed bench for block_reduce_reader: full, all-ones, short, back-pressure, reset.
module tb_block_reduce_reader;
  localparam int N     = 32;
  localparam int DEPTH = 64;
  localparam int CNT_W = 7;
  localparam int SUM_W = 38;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             EN_reduce;
  logic             VALID_memVal;
  logic [N-1:0]     memVal_data;
  logic             EN_blockRead;
  logic             VALID_result;
  logic             RDY_result;
  logic [SUM_W-1:0] result_sum;
  logic [N-1:0]     result_min;
  logic [N-1:0]     result_max;
  logic [CNT_W-1:0] result_count;
  logic             ERR_short;

  int checks   = 0;
  int failures = 0;

  block_reduce_reader #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .EN_reduce    (EN_reduce),
    .VALID_memVal (VALID_memVal),
    .memVal_data  (memVal_data),
    .EN_blockRead (EN_blockRead),
    .VALID_result (VALID_result),
    .RDY_result   (RDY_result),
    .result_sum   (result_sum),
    .result_min   (result_min),
    .result_max   (result_max),
    .result_count (result_count),
    .ERR_short    (ERR_short)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_record(input string tag, input logic [63:0] sum, input logic [31:0] mn,
                            input logic [31:0] mx, input int cnt, input logic err);
    chk({tag, "_sum"}, 64'(result_sum), sum);
    chk({tag, "_min"}, 64'(result_min), 64'(mn));
    chk({tag, "_max"}, 64'(result_max), 64'(mx));
    chk({tag, "_count"}, 64'(result_count), 64'(cnt));
    chk({tag, "_err"}, 64'(ERR_short), 64'(err));
    $display("record %s: sum=%0d min=%0h max=%0h count=%0d err=%0b",
             tag, result_sum, result_min, result_max, result_count, ERR_short);
  endtask

  // Called at a negedge; arms, waits for the request, streams n words, waits for the record.
  task automatic run_block(input int n, input logic [31:0] first, input logic [31:0] step);
    int k;
    EN_reduce = 1'b1;
    k = 0;
    while (EN_blockRead !== 1'b1 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("req_seen", 64'(EN_blockRead), 64'd1);
    for (int i = 0; i < n; i++) begin
      VALID_memVal = 1'b1;
      memVal_data  = first + i * step;
      @(negedge CLK);
      if (i == 0 && n > 1) chk("req_drop", 64'(EN_blockRead), 64'd0);
    end
    VALID_memVal = 1'b0;
    memVal_data  = '0;
    if (n == DEPTH) chk("latency", 64'(VALID_result), 64'd1);
    k = 0;
    while (VALID_result !== 1'b1 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("valid_seen", 64'(VALID_result), 64'd1);
  endtask

  task automatic handshake();
    RDY_result = 1'b1;
    @(negedge CLK);
    chk("hs_valid_low", 64'(VALID_result), 64'd0);
    RDY_result = 1'b0;
  endtask

  initial begin
    RST_N        = 1'b0;
    EN_reduce    = 1'b0;
    VALID_memVal = 1'b0;
    memVal_data  = '0;
    RDY_result   = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_req",   64'(EN_blockRead), 64'd0);
    chk("rst_valid", 64'(VALID_result), 64'd0);
    chk("rst_sum",   64'(result_sum),   64'd0);
    chk("rst_min",   64'(result_min),   64'd0);
    chk("rst_count", 64'(result_count), 64'd0);
    chk("rst_err",   64'(ERR_short),    64'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Ascending 1..64, then hold the record for 20 cycles with stray valid data.
    run_block(64, 32'd1, 32'd1);
    chk_record("ramp", 64'd2080, 32'd1, 32'd64, 64, 1'b0);
    for (int c = 0; c < 20; c++) begin
      VALID_memVal = (c % 3 == 0);
      memVal_data  = 32'd5;
      @(negedge CLK);
      chk("bp_valid", 64'(VALID_result), 64'd1);
      chk("bp_req",   64'(EN_blockRead), 64'd0);
      chk("bp_sum",   64'(result_sum),   64'd2080);
      chk("bp_count", 64'(result_count), 64'd64);
    end
    VALID_memVal = 1'b0;
    memVal_data  = '0;
    chk_record("ramp_held", 64'd2080, 32'd1, 32'd64, 64, 1'b0);
    handshake();
    chk("hs_idle_req", 64'(EN_blockRead), 64'd0);
    @(negedge CLK);
    chk("rearm_req", 64'(EN_blockRead), 64'd1);

    // All-ones block: sum fills the widened accumulator exactly.
    run_block(64, 32'hFFFF_FFFF, 32'd0);
    chk_record("ones", 64'h3F_FFFF_FFC0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64, 1'b0);
    handshake();

    // Short stream of 10 words 100,103,..,127.
    run_block(10, 32'd100, 32'd3);
    chk_record("short", 64'd1135, 32'd100, 32'd127, 10, 1'b1);
    handshake();

    // Multiplier-style results i*2 for i=0..63.
    run_block(64, 32'd0, 32'd2);
    chk_record("mult", 64'd4032, 32'd0, 32'd126, 64, 1'b0);
    chk("mult_err_cleared", 64'(ERR_short), 64'd0);
    handshake();

    // Reset after 30 words of an in-progress block.
    EN_reduce = 1'b1;
    @(negedge CLK);
    chk("mid_req", 64'(EN_blockRead), 64'd1);
    for (int i = 0; i < 30; i++) begin
      VALID_memVal = 1'b1;
      memVal_data  = 32'd7;
      @(negedge CLK);
    end
    RST_N = 1'b0;
    #1;
    chk("mid_rst_req",   64'(EN_blockRead), 64'd0);
    chk("mid_rst_valid", 64'(VALID_result), 64'd0);
    chk("mid_rst_sum",   64'(result_sum),   64'd0);
    chk("mid_rst_count", 64'(result_count), 64'd0);
    chk("mid_rst_min",   64'(result_min),   64'd0);
    @(negedge CLK);
    RST_N        = 1'b1;
    EN_reduce    = 1'b0;
    VALID_memVal = 1'b0;
    memVal_data  = '0;
    @(negedge CLK);
    chk("post_rst_req",   64'(EN_blockRead), 64'd0);
    chk("post_rst_valid", 64'(VALID_result), 64'd0);

    // Disarming while in REQ returns to IDLE.
    EN_reduce = 1'b1;
    @(negedge CLK);
    chk("disarm_req_on", 64'(EN_blockRead), 64'd1);
    EN_reduce = 1'b0;
    @(negedge CLK);
    chk("disarm_req_off", 64'(EN_blockRead), 64'd0);

    // Descending 64..1 exercises min tracking after the first word.
    run_block(64, 32'd64, 32'hFFFF_FFFF);
    chk_record("desc", 64'd2080, 32'd1, 32'd64, 64, 1'b0);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
